// File: rtl/bitwise_reduce_pkg.sv
// Shared definitions for the bitwise_reduce engine: op codes, FSM states and
// the identity value that seeds the accumulator for each operation.
package bitwise_reduce_pkg;

    typedef enum logic [1:0] {
        OpAnd  = 2'b00,
        OpOr   = 2'b01,
        OpXor  = 2'b10,
        OpNand = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAccum = 2'b01,
        StDone  = 2'b10
    } state_e;

    // AND-type folds start from all-ones, OR/XOR folds from all-zeros.
    function automatic logic identity_bit(op_e op);
        return (op == OpAnd) || (op == OpNand);
    endfunction

    // NAND accumulates as AND; the inversion is applied once to the final word.
    function automatic logic invert_result(op_e op);
        return op == OpNand;
    endfunction

endpackage

// File: rtl/bitwise_op.sv
// Combinational per-beat fold: combines the running accumulator with one operand.
module bitwise_op
    import bitwise_reduce_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OpAnd, OpNand: y = a & b;
            OpOr:          y = a | b;
            OpXor:         y = a ^ b;
            default:       y = a & b;
        endcase
    end

endmodule

// File: rtl/bitwise_reduce.sv
// Multi-operand logic engine: folds len operands with AND/OR/XOR/NAND behind
// valid/ready handshakes on both the operand and result streams.
module bitwise_reduce
    import bitwise_reduce_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             err
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] OneLen = LEN_W'(1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             err_q, err_d;

    logic             len_ok;
    logic             last_beat;
    op_e              op_in;
    logic [WIDTH-1:0] fold_y;

    assign op_in     = op_e'(op);
    assign len_ok    = (len != '0) && (len <= MaxLen);
    assign last_beat = (count_q == len_q - OneLen);

    bitwise_op #(
        .WIDTH (WIDTH)
    ) u_fold (
        .op (op_q),
        .a  (acc_q),
        .b  (in_data),
        .y  (fold_y)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        len_d      = len_q;
        count_d    = count_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        err_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_ok) begin
                        op_d    = op_in;
                        len_d   = len;
                        acc_d   = {WIDTH{identity_bit(op_in)}};
                        count_d = '0;
                        state_d = StAccum;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StAccum: begin
                // in_ready is high throughout ACCUM, so in_valid alone marks a beat.
                if (in_valid) begin
                    acc_d   = fold_y;
                    count_d = count_q + OneLen;
                    if (last_beat) begin
                        out_data_d = invert_result(op_q) ? ~fold_y : fold_y;
                        state_d    = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= OpAnd;
            len_q      <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_q      <= len_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule
